// File: rtl/dcache_controller.sv
// Direct-mapped-style data cache controller: hit path is combinational off the
// cache SRAM, misses run write-back / refill against a line-wide memory port.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_wen_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_t;

    typedef struct packed {
        logic         en;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_req_t;

    state_t   state_q, state_d;
    mem_req_t mem_q, mem_d;

    logic [22:0]  cpu_tag;
    logic [3:0]   cpu_index;
    logic [2:0]   cpu_word;
    logic [31:0]  cpu_line_addr;
    logic [31:0]  victim_line_addr;
    logic [255:0] merged_line;
    logic [1:0]   tag_flags;
    logic         sram_we;

    assign cpu_tag          = cpu_addr_i[31:9];
    assign cpu_index        = cpu_addr_i[8:5];
    assign cpu_word         = cpu_addr_i[4:2];
    assign cpu_line_addr    = {cpu_tag, cpu_index, 5'b0};
    assign victim_line_addr = {sram_tag_i[22:0], cpu_index, 5'b0};

    assign cpu_data_o    = sram_data_i[{cpu_word, 5'b0} +: 32];
    assign sram_addr_o   = cpu_index;
    assign sram_tag_o    = {tag_flags, cpu_tag};
    assign sram_enable_o = sram_we;
    assign sram_write_o  = sram_we;

    assign mem_enable_o = mem_q.en;
    assign mem_write_o  = mem_q.wr;
    assign mem_addr_o   = mem_q.addr;
    assign mem_data_o   = mem_q.data;

    always_comb begin
        merged_line = sram_data_i;
        merged_line[{cpu_word, 5'b0} +: 32] = cpu_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        cpu_stall_o = 1'b0;
        sram_we     = 1'b0;
        tag_flags   = 2'b00;
        sram_data_o = sram_data_i;

        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (sram_hit_i) begin
                        if (cpu_wen_i) begin
                            sram_we     = 1'b1;
                            tag_flags   = 2'b11;
                            sram_data_o = merged_line;
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = MISS;
                    end
                end
            end
            MISS: begin
                cpu_stall_o = 1'b1;
                // Valid and dirty victim must go out before its slot is reused
                if (sram_tag_i[24] && sram_tag_i[23]) begin
                    mem_d   = '{en: 1'b1, wr: 1'b1, addr: victim_line_addr, data: sram_data_i};
                    state_d = WRITEBACK;
                end else begin
                    mem_d.en   = 1'b1;
                    mem_d.wr   = 1'b0;
                    mem_d.addr = cpu_line_addr;
                    state_d    = REFILL;
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    mem_d.wr   = 1'b0;
                    mem_d.addr = cpu_line_addr;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    sram_we     = 1'b1;
                    tag_flags   = 2'b10;
                    sram_data_o = mem_data_i;
                    mem_d.en    = 1'b0;
                    state_d     = REFILL_DONE;
                end
            end
            REFILL_DONE: begin
                cpu_stall_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset overrides everything visible to the CPU and the SRAM
        if (rst_i) begin
            cpu_stall_o = 1'b0;
            sram_we     = 1'b0;
        end
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have no parameters; address split is fixed: tag = addr[31:9] (23 bits), index = addr[8:5] (4 bits), word = addr[4:2], byte offset addr[1:0] ignored.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 cpu_req_i  input  1  CPU access request.
REQ-005 cpu_wen_i  input  1  1 = store, 0 = load.
REQ-006 cpu_addr_i  input  32  CPU byte address.
REQ-007 cpu_data_i  input  32  store data.
REQ-008 cpu_data_o  output  32  load data.
REQ-009 cpu_stall_o  output  1  CPU must hold request and wait.
REQ-010 sram_addr_o  output  4  set index to cache SRAM.
REQ-011 sram_tag_o  output  25  {valid, dirty, tag[22:0]} to cache SRAM.
REQ-012 sram_data_o  output  256  line written to cache SRAM.
REQ-013 sram_enable_o / sram_write_o  output  1 each  cache SRAM write strobe pair.
REQ-014 sram_tag_i  input  25  SRAM tag out (hit way, else LRU victim).
REQ-015 sram_data_i  input  256  SRAM line out (hit way, else LRU victim).
REQ-016 sram_hit_i  input  1  SRAM hit.
REQ-017 mem_enable_o / mem_write_o  output  1 each  memory request and direction.
REQ-018 mem_addr_o  output  32  line-aligned memory address (bits[4:0] = 0).
REQ-019 mem_data_o  output  256  write-back line.
REQ-020 mem_data_i  input  256  refill line; mem_ack_i  input  1  one-cycle completion pulse.

Function
REQ-021 sram_addr_o SHALL equal cpu_addr_i[8:5] and sram_tag_o[22:0] SHALL equal cpu_addr_i[31:9] combinationally in every state.
REQ-022 FSM states SHALL be IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
REQ-023 IDLE, cpu_req_i=1, sram_hit_i=1, load: cpu_data_o SHALL be sram_data_i word addr[4:2] (bits 32*w+31:32*w) in the same cycle, cpu_stall_o=0, state stays IDLE.
REQ-024 IDLE store hit: same cycle, sram_enable_o=sram_write_o=1, sram_data_o = sram_data_i with word addr[4:2] replaced by cpu_data_i, sram_tag_o[24:23]=2'b11, cpu_stall_o=0.
REQ-025 IDLE, cpu_req_i=1, sram_hit_i=0: cpu_stall_o=1 combinationally; next state MISS.
REQ-026 cpu_stall_o SHALL be 1 in MISS, WRITEBACK, REFILL, REFILL_DONE; 0 in IDLE with no request.
REQ-027 MISS (one cycle): if sram_tag_i[24]&sram_tag_i[23], register mem_enable_o=1, mem_write_o=1, mem_addr_o={sram_tag_i[22:0], index, 5'b0}, mem_data_o=sram_data_i, go WRITEBACK; else register mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}, go REFILL.
REQ-028 WRITEBACK: hold memory outputs until mem_ack_i=1; then register a read at {cpu tag, index, 5'b0}, mem_write_o=0, mem_enable_o stays 1, go REFILL.
REQ-029 REFILL: hold read until mem_ack_i=1; in that cycle assert sram_enable_o=sram_write_o=1, sram_data_o=mem_data_i, sram_tag_o[24:23]=2'b10; register mem_enable_o=0; go REFILL_DONE.
REQ-030 REFILL_DONE: no SRAM or memory activity; go IDLE, where the held request re-evaluates and hits (store then merges per REQ-024).
REQ-031 mem_ack_i outside WRITEBACK/REFILL SHALL be ignored; memory outputs SHALL be registered and stable while mem_enable_o=1.
REQ-032 sram_enable_o/sram_write_o SHALL be 0 in all cases not named in REQ-024/029; cpu_req_i changes while stalled are undefined input.

Reset
REQ-033 rst_i=1 at a clock edge SHALL force state IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0 from the next cycle, including mid-WRITEBACK/REFILL (transfer abandoned, no SRAM write).
REQ-034 While rst_i=1, sram_enable_o=sram_write_o=0 and cpu_stall_o=0.

Verification
REQ-035 Load hit: line word2=0xDEADBEEF, addr 0x0000_0128 -> cpu_data_o=0xDEADBEEF same cycle, cpu_stall_o=0.
REQ-036 Clean load miss addr 0x0000_1040, victim tag valid=1 dirty=0 -> MISS, read at 0x0000_1040, ack after 5 cycles, SRAM write with tag[24:23]=10, REFILL_DONE, IDLE, hit, stall drops.
REQ-037 Dirty miss, victim tag 0x000123 at index 3 -> write-back at 0x0002_4660 with victim line, then read of CPU line, exactly one SRAM write.
REQ-038 Store hit addr word 7 data 0x12345678 -> single-cycle SRAM write, only bits[255:224] changed, tag[24:23]=11.
REQ-039 Store miss -> refill, then store merged on return to IDLE, final tag dirty=1.
REQ-040 rst_i asserted two cycles into REFILL -> mem_enable_o=0 next cycle, state IDLE, later mem_ack_i ignored, no SRAM write.
